text_writer: RTL and testbench

- Character-stream writer for the VGA text display: accepts ASCII bytes over a valid/ready handshake and writes them into the screen character RAM through its write port.
- The pixel pipeline reads that RAM to drive the font ROM; this block is the write side of the same buffer.
- Maintains the cursor, decodes a small set of control codes, and clears the screen on reset/form-feed and clears each new line.

---
 rtl/text_writer_pkg.sv | 14 +
 rtl/text_writer.sv | 122 ++++++++++++
 tb/tb_text_writer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/text_writer_pkg.sv
// text_writer_pkg: ASCII control codes, screen geometry defaults and writer states
package text_writer_pkg;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam int TEXT_COLS = 20;
  localparam int TEXT_ROWS = 15;
  typedef enum logic [1:0] {IDLE, CLEAR_ALL, CLEAR_LINE} state_t;
  function automatic logic is_printable(input logic [7:0] c);
    return c >= 8'h20 && c <= 8'h7E;
  endfunction
endpackage

// File: rtl/text_writer.sv
// text_writer: character-stream writer for the VGA text RAM write port
//   px_clk, rst (sync, active-high)
//   char_data/char_valid/char_ready : ASCII byte handshake in
//   wr_en/wr_addr/wr_data           : registered text RAM write port
//   cursor_col/cursor_row           : registered cursor position
//   busy                            : screen or line clear in progress
module text_writer
  import text_writer_pkg::*;
#(
  parameter int COLS   = TEXT_COLS,
  parameter int ROWS   = TEXT_ROWS,
  parameter int ADDR_W = 9
) (
  input  logic                     px_clk,
  input  logic                     rst,
  input  logic [7:0]               char_data,
  input  logic                     char_valid,
  output logic                     char_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [7:0]               wr_data,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic [$clog2(ROWS)-1:0]  cursor_row,
  output logic                     busy
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int IW = ADDR_W + 1;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] col_n;
  logic [RW-1:0] row_n, row_inc;
  logic [ADDR_W-1:0] row_base, base_n, base_inc, addr_n;
  logic [7:0] data_n;
  logic en_n, wrap_row, last_col, newline;
  assign char_ready = state == IDLE;
  assign busy       = state == CLEAR_ALL || state == CLEAR_LINE;
  assign wrap_row   = cursor_row == RW'(ROWS - 1);
  assign last_col   = cursor_col == CW'(COLS - 1);
  assign row_inc    = wrap_row ? '0 : cursor_row + 1'b1;
  // row_base tracks row*COLS so no multiplier is needed for addressing
  assign base_inc   = wrap_row ? '0 : row_base + ADDR_W'(COLS);
  assign newline    = char_data == ASCII_LF || (is_printable(char_data) && last_col);
  always_comb begin
    state_n = state;
    idx_n   = idx;
    col_n   = cursor_col;
    row_n   = cursor_row;
    base_n  = row_base;
    en_n    = 1'b0;
    addr_n  = wr_addr;
    data_n  = wr_data;
    case (state)
      CLEAR_ALL, CLEAR_LINE: begin
        // idx runs one past the last cell so busy covers the final visible write
        if (idx == (state == CLEAR_ALL ? IW'(COLS * ROWS) : IW'(COLS))) state_n = IDLE;
        else begin
          en_n   = 1'b1;
          addr_n = (state == CLEAR_ALL ? '0 : row_base) + ADDR_W'(idx);
          data_n = ASCII_SPACE;
          idx_n  = idx + 1'b1;
        end
      end
      IDLE: if (char_valid) begin
        if (is_printable(char_data)) begin
          en_n   = 1'b1;
          addr_n = row_base + ADDR_W'(cursor_col);
          data_n = char_data;
          col_n  = cursor_col + 1'b1;
        end else if (char_data == ASCII_CR) col_n = '0;
        else if (char_data == ASCII_BS && cursor_col != '0) begin
          col_n  = cursor_col - 1'b1;
          en_n   = 1'b1;
          addr_n = row_base + ADDR_W'(col_n);
          data_n = ASCII_SPACE;
        end else if (char_data == ASCII_FF) begin
          // cell 0 is written straight away, so the clear resumes at index 1
          state_n = CLEAR_ALL;
          col_n   = '0;
          row_n   = '0;
          base_n  = '0;
          en_n    = 1'b1;
          addr_n  = '0;
          data_n  = ASCII_SPACE;
          idx_n   = IW'(1);
        end
        if (newline) begin
          state_n = CLEAR_LINE;
          col_n   = '0;
          row_n   = row_inc;
          base_n  = base_inc;
          idx_n   = '0;
        end
      end
      default: begin
        state_n = CLEAR_ALL;
        idx_n   = '0;
      end
    endcase
  end
  always_ff @(posedge px_clk) begin
    if (rst) begin
      state      <= CLEAR_ALL;
      idx        <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      row_base   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cursor_col <= col_n;
      cursor_row <= row_n;
      row_base   <= base_n;
      wr_en      <= en_n;
      wr_addr    <= addr_n;
      wr_data    <= data_n;
    end
  end
endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: self-checking bench for text_writer (vectors, corner sequences, random vs screen model)
module tb_text_writer;
  localparam int COLS = 20;
  localparam int ROWS = 15;
  logic px_clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] char_data = 8'h00;
  logic char_valid = 1'b0;
  logic char_ready, wr_en, busy;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] cursor_col;
  logic [3:0] cursor_row;
  int total = 0;
  int bad = 0;
  int wcount = 0;
  logic [7:0] dut_scr [512];
  logic [7:0] ref_scr [COLS*ROWS];
  int rc, rr, nw;
  typedef struct {
    logic [7:0] c;
    logic       en;
    int         addr;
    logic [7:0] data;
    int         col;
  } vec_t;
  vec_t tbl [14];

  text_writer dut (
    .px_clk(px_clk), .rst(rst), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 px_clk = ~px_clk;

  always @(negedge px_clk) if (wr_en) begin
    dut_scr[wr_addr] <= wr_data;
    wcount <= wcount + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge px_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    char_data = c;
    char_valid = 1'b1;
    while (!char_ready && n < 2000) begin
      step();
      n++;
    end
    check("send_ready", char_ready, 1);
    step();
    char_valid = 1'b0;
  endtask

  // checks n consecutive space writes from base, then the return to idle
  task automatic expect_clear(input string nm, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      check(nm, {wr_en, busy, char_ready, wr_data, wr_addr}, {1'b1, 1'b1, 1'b0, 8'h20, 9'(base + i)});
      step();
    end
    check({nm, "_end"}, {wr_en, busy, char_ready}, 3'b001);
  endtask

  task automatic model_nl();
    rr = (rr + 1) % ROWS;
    for (int i = 0; i < COLS; i++) ref_scr[rr*COLS + i] = 8'h20;
    nw += COLS;
  endtask

  task automatic model(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      ref_scr[rr*COLS + rc] = c;
      nw++;
      rc++;
      if (rc == COLS) begin
        rc = 0;
        model_nl();
      end
    end else if (c == 8'h0D) rc = 0;
    else if (c == 8'h0A) begin
      rc = 0;
      model_nl();
    end else if (c == 8'h08) begin
      if (rc > 0) begin
        rc--;
        ref_scr[rr*COLS + rc] = 8'h20;
        nw++;
      end
    end else if (c == 8'h0C) begin
      for (int i = 0; i < COLS*ROWS; i++) ref_scr[i] = 8'h20;
      nw += COLS*ROWS;
      rc = 0;
      rr = 0;
    end
  endtask

  initial begin
    int w0, mism;
    tbl[0]  = '{8'h41, 1'b1, 0, 8'h41, 1};
    tbl[1]  = '{8'h42, 1'b1, 1, 8'h42, 2};
    tbl[2]  = '{8'h07, 1'b0, 0, 8'h00, 2};
    tbl[3]  = '{8'h7F, 1'b0, 0, 8'h00, 2};
    tbl[4]  = '{8'h08, 1'b1, 1, 8'h20, 1};
    tbl[5]  = '{8'h0D, 1'b0, 0, 8'h00, 0};
    tbl[6]  = '{8'h08, 1'b0, 0, 8'h00, 0};
    tbl[7]  = '{8'h78, 1'b1, 0, 8'h78, 1};
    tbl[8]  = '{8'h7E, 1'b1, 1, 8'h7E, 2};
    tbl[9]  = '{8'h80, 1'b0, 0, 8'h00, 2};
    tbl[10] = '{8'hFF, 1'b0, 0, 8'h00, 2};
    tbl[11] = '{8'h30, 1'b1, 2, 8'h30, 3};
    tbl[12] = '{8'h1F, 1'b0, 0, 8'h00, 3};
    tbl[13] = '{8'h20, 1'b1, 3, 8'h20, 4};

    step();
    step();
    check("rst_outputs", {wr_en, wr_addr, wr_data, char_ready, busy}, {1'b0, 9'd0, 8'h00, 1'b0, 1'b1});
    check("rst_cursor", {cursor_row, cursor_col}, 9'd0);
    rst = 1'b0;
    step();
    expect_clear("clr_all", 0, COLS*ROWS);
    check("clr_all_busy", busy, 0);

    for (int i = 0; i < 14; i++) begin
      send(tbl[i].c);
      check("vec_en", wr_en, tbl[i].en);
      if (tbl[i].en) check("vec_wr", {wr_addr, wr_data}, {9'(tbl[i].addr), tbl[i].data});
      check("vec_cursor", {cursor_row, cursor_col}, {4'd0, 5'(tbl[i].col)});
      check("vec_ready", char_ready, 1);
    end
    step();
    check("idle_no_wr", wr_en, 0);

    send(8'h0D);
    for (int i = 0; i < 19; i++) send(8'(8'h61 + i));
    check("pre_wrap_cursor", {cursor_row, cursor_col}, {4'd0, 5'd19});
    send(8'h5A);
    check("wrap_wr", {wr_en, wr_addr, wr_data}, {1'b1, 9'd19, 8'h5A});
    check("wrap_cursor", {cursor_row, cursor_col, char_ready}, {4'd1, 5'd0, 1'b0});
    step();
    expect_clear("line_wrap", 20, COLS);

    for (int i = 0; i < 13; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h2A);
    check("pre_lf_cursor", {cursor_row, cursor_col}, {4'd14, 5'd5});
    send(8'h0A);
    check("lf_no_wr", {wr_en, busy}, 2'b01);
    check("lf_cursor", {cursor_row, cursor_col}, 9'd0);
    step();
    expect_clear("lf_wrap", 0, COLS);

    send(8'h0A);
    send(8'h0A);
    send(8'h58);
    check("bs_x", {wr_en, wr_addr, wr_data}, {1'b1, 9'd40, 8'h58});
    send(8'h08);
    check("bs_1", {wr_en, wr_addr, wr_data}, {1'b1, 9'd40, 8'h20});
    check("bs_1_cursor", {cursor_row, cursor_col}, {4'd2, 5'd0});
    send(8'h08);
    check("bs_2", wr_en, 0);
    check("bs_2_cursor", {cursor_row, cursor_col}, {4'd2, 5'd0});

    send(8'h0A);
    for (int i = 0; i < 7; i++) send(8'h2B);
    check("pre_ff_cursor", {cursor_row, cursor_col}, {4'd3, 5'd7});
    send(8'h0C);
    check("ff_cursor", {cursor_row, cursor_col}, 9'd0);
    expect_clear("ff_clear", 0, COLS*ROWS);

    send(8'h0C);
    for (int i = 0; i < 150; i++) step();
    check("ff_mid", {wr_en, wr_addr}, {1'b1, 9'd150});
    rst = 1'b1;
    step();
    check("mid_rst", {wr_en, busy, char_ready, wr_addr}, {1'b0, 1'b1, 1'b0, 9'd0});
    rst = 1'b0;
    step();
    expect_clear("rst_restart", 0, COLS*ROWS);

    rc = 0;
    rr = 0;
    nw = 0;
    for (int i = 0; i < COLS*ROWS; i++) ref_scr[i] = 8'h20;
    w0 = wcount;
    for (int k = 0; k < 400; k++) begin
      logic [7:0] c;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 5) c = 8'($urandom_range(32, 126));
      else if (sel == 6) c = 8'h0A;
      else if (sel == 7) c = 8'h0D;
      else if (sel == 8) c = 8'h08;
      else c = ($urandom_range(0, 24) == 0) ? 8'h0C : 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) step();
      send(c);
      model(c);
      check("rnd_cursor", {cursor_row, cursor_col}, {4'(rr), 5'(rc)});
    end
    for (int n = 0; n < 1000 && !char_ready; n++) step();
    check("rnd_idle", char_ready, 1);
    step();
    step();
    mism = 0;
    for (int i = 0; i < COLS*ROWS; i++) if (dut_scr[i] !== ref_scr[i]) mism++;
    check("rnd_screen", mism, 0);
    check("rnd_writes", wcount - w0, nw);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
